i2s_mic_tx: RTL

- Synthesizable I2S MEMS-microphone transmitter, i.e. the microphone end of the mic link. Our mic subsystem is the clock/WS master; this block is the slave.
- Runs on the system clock and oversamples the master's SCK and WS. Samples come from a small internal FIFO, and the block shifts them out MSB-first in the slot selected by its LR pin.
- Used as a bit-exact stimulus source for hardware-in-the-loop checks of the mic/xcorr path, and as an FPGA loopback mic model.

---
 rtl/i2s_mic_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_mic_tx.sv
// i2s_mic_tx: I2S slave transmitter modelling a MEMS microphone.
// Oversamples the master's SCK/WS on clk, pulls samples from a small FIFO
// and shifts them out MSB-first in the slot selected by mic_lr.
module i2s_mic_tx #(
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mic_sck,
  input  logic          mic_ws,
  input  logic          mic_lr,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          mic_sd,
  output logic          mic_sd_oe,
  output logic          underrun,
  output logic          word_done
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int BCW = (DW > 1) ? $clog2(DW + 1) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_PAD   = 2'd3;

  // ---------------------------------------------------------------------
  // Synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [2:0] sck_q;     // [0],[1] synchroniser, [2] edge-detect history
  logic [1:0] ws_q;      // 2-flop synchroniser
  logic       ws_s_q;    // WS as sampled on the last SCK rise
  logic       ws_vld_q;  // ws_s_q holds a real sample (first rise after reset seen)
  logic       sck_rise, sck_fall;
  logic       ws_edge, own_edge, oth_edge;

  // Shift SCK/WS through their synchronisers every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= '0;
      ws_q  <= '0;
    end else begin
      sck_q <= {sck_q[1:0], mic_sck};
      ws_q  <= {ws_q[0], mic_ws};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];

  // The incoming sample is compared against the previous one at the rise
  // strobe itself, so the slot decision lands before the following SCK fall
  // even at the minimum 4x oversampling ratio. The first rise after reset
  // only seeds ws_s_q, so a slot already in progress at release is skipped.
  assign ws_edge  = sck_rise & ws_vld_q & (ws_q[1] != ws_s_q);
  assign own_edge = ws_edge & (ws_q[1] == mic_lr);
  assign oth_edge = ws_edge & (ws_q[1] != mic_lr);

  // Capture WS on each SCK rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_s_q   <= 1'b0;
      ws_vld_q <= 1'b0;
    end else if (sck_rise) begin
      ws_s_q   <= ws_q[1];
      ws_vld_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop, fifo_empty;

  assign s_ready    = (cnt_q != CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = s_valid & s_ready;
  // Pop decision uses the pre-push count: a word written in the same clk
  // as an empty-slot start waits for the next slot.
  assign pop        = own_edge & ~fifo_empty;

  // Storage array, no reset needed: contents are qualified by cnt_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Slot state machine and shifter
  // ---------------------------------------------------------------------
  logic [1:0]     state_q, state_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           sd_q, sd_d;
  logic           oe_q, oe_d;
  logic           ur_q, ur_d;
  logic           wd_q, wd_d;

  // Next-state logic; a WS edge always wins over an SCK fall
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sd_d      = sd_q;
    oe_d      = oe_q;
    ur_d      = 1'b0;
    wd_d      = 1'b0;
    if (own_edge) begin
      // Our slot begins: the line still carries the previous slot's last
      // bit for one SCK, so stay off it until the ARMED fall.
      shreg_d   = pop ? mem_q[rd_ptr_q] : '0;
      ur_d      = fifo_empty;
      bit_cnt_d = '0;
      sd_d      = 1'b0;
      oe_d      = 1'b0;
      state_d   = ST_ARMED;
    end else if (oth_edge) begin
      // Other channel's slot: release the line and wait in IDLE
      sd_d    = 1'b0;
      oe_d    = 1'b0;
      state_d = ST_IDLE;
    end else if (sck_fall) begin
      case (state_q)
        ST_ARMED: begin
          oe_d      = 1'b1;
          sd_d      = shreg_q[DW-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = BCW'(1);
          if (DW == 1) begin
            wd_d    = 1'b1;
            state_d = ST_PAD;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sd_d      = shreg_q[DW-1];
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DW - 1)) begin
            wd_d    = 1'b1;
            state_d = ST_PAD;
          end
        end
        ST_PAD: begin
          sd_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset aborts any slot in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sd_q      <= 1'b0;
      oe_q      <= 1'b0;
      ur_q      <= 1'b0;
      wd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sd_q      <= sd_d;
      oe_q      <= oe_d;
      ur_q      <= ur_d;
      wd_q      <= wd_d;
    end
  end

  assign mic_sd    = sd_q;
  assign mic_sd_oe = oe_q;
  assign underrun  = ur_q;
  assign word_done = wd_q;

endmodule
